// File: rtl/sincronizador_de_fifo_de_envio_if.sv
// Handshake bundle between the transmit synchroniser, the source FIFO and the UART tx FIFO.
// The master modport is the synchroniser side; slave is the surrounding environment.
interface sincronizador_de_fifo_de_envio_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              src_empty;
    logic [DATA_W-1:0] src_data;
    logic              rd_src;
    logic              wr_uart_full;
    logic              wr_uart;
    logic [DATA_W-1:0] w_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent;

    modport master (
        input  start, abort, src_empty, src_data, wr_uart_full,
        output rd_src, wr_uart, w_data, busy, done, sent
    );

    modport slave (
        output start, abort, src_empty, src_data, wr_uart_full,
        input  rd_src, wr_uart, w_data, busy, done, sent
    );
endinterface

// File: rtl/sincronizador_de_fifo_de_envio.sv
// Moves a burst of A_ENVIAR words from a FWFT source FIFO into the UART tx FIFO.
// Each move pops and pushes in the same cycle; a one-cycle done pulse closes every burst.
module sincronizador_de_fifo_de_envio #(
    parameter int A_ENVIAR = 32,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    sincronizador_de_fifo_de_envio_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(A_ENVIAR - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_s;
    logic              move_s;
    logic [DATA_W-1:0] w_data_s;

    // State and burst counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next state, counter update and the combinational move strobe
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        move_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = XFER;
                    count_s = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                // abort wins over a move that would otherwise happen this cycle
                if (bus.abort) begin
                    state_s = FIN;
                end else if (!bus.src_empty && !bus.wr_uart_full) begin
                    move_s  = 1'b1;
                    count_s = count_r + ONE_CNT;
                    if (count_r == LAST_CNT) begin
                        state_s = FIN;
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    state_s = XFER;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                count_s = {CNT_W{1'b0}};
            end
        endcase
    end

    assign w_data_s     = bus.src_data;
    assign bus.w_data   = w_data_s;
    assign bus.rd_src   = move_s;
    assign bus.wr_uart  = move_s;
    assign bus.busy     = (state_r == XFER);
    assign bus.done     = (state_r == FIN);
    assign bus.sent     = count_r;
endmodule

// File: tb/tb_sincronizador_de_fifo_de_envio.sv
// Randomised scoreboard bench for the transmit FIFO synchroniser.
module tb_sincronizador_de_fifo_de_envio;
    localparam int A_ENVIAR = 32;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 16;

    typedef struct {
        int sent;
        bit aborted;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset;

    sincronizador_de_fifo_de_envio_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sincronizador_de_fifo_de_envio #(
        .A_ENVIAR(A_ENVIAR),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    done_exp_t         done_q[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int last_wr_cyc = -10;
    int done_total  = 0;
    int busy_total  = 0;
    bit busy_prev   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Source FIFO model: head word is visible while not empty; optional random empties and periodic full
    task automatic drive_src(input bit stall, input int n);
        bus.wr_uart_full = stall ? (((n / 3) % 2) == 1) : 1'b0;
        bus.src_empty    = (src_q.size() == 0) || (stall && ($urandom_range(0, 3) == 0));
        bus.src_data     = (src_q.size() != 0) ? src_q[0] : DATA_W'($urandom);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pushes a word or pulses done
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("rd_eq_wr", {63'd0, bus.rd_src}, {63'd0, bus.wr_uart});
                if (bus.rd_src)
                    check("rd_while_empty", {63'd0, bus.src_empty}, 64'd0);
                if (bus.wr_uart) begin
                    check("wr_while_full", {63'd0, bus.wr_uart_full}, 64'd0);
                    if (exp_q.size() == 0)
                        fail_now("unexpected_push");
                    else
                        check("w_data", {56'd0, bus.w_data}, {56'd0, exp_q.pop_front()});
                    last_wr_cyc = cyc;
                end
                if (bus.busy && !busy_prev)
                    check("sent_at_start", {48'd0, bus.sent}, 64'd0);
                if (bus.busy)
                    busy_total++;
                if (bus.done) begin
                    done_total++;
                    check("busy_in_fin", {63'd0, bus.busy}, 64'd0);
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        e = done_q.pop_front();
                        check("sent", {48'd0, bus.sent}, 64'(e.sent));
                        if (!e.aborted)
                            check("done_latency", 64'(cyc), 64'(last_wr_cyc + 1));
                    end
                end
                busy_prev = bus.busy;
            end else begin
                busy_prev = 1'b0;
            end
        end
    end

    // One scenario: nb bursts (start held when nb>1), optional stalls, abort or reset after N words
    task automatic run(input int nb, input bit stall, input int abort_at, input int reset_at, input bit seq);
        int  moved = 0;
        int  dones = 0;
        int  n     = 0;
        int  total = nb * A_ENVIAR;
        int  remain;
        int  busy0;
        int  done0;
        bit  pop_now;
        bit  d;
        bit  aborted = 1'b0;
        src_q.delete();
        for (int i = 0; i < total; i++)
            src_q.push_back(seq ? DATA_W'(i) : DATA_W'($urandom));
        if (reset_at > 0) begin
            for (int i = 0; i < reset_at; i++) exp_q.push_back(src_q[i]);
            remain = total - reset_at;
        end else if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) exp_q.push_back(src_q[i]);
            done_q.push_back('{abort_at, 1'b1});
            remain = total - abort_at;
        end else begin
            for (int i = 0; i < total; i++) exp_q.push_back(src_q[i]);
            for (int i = 0; i < nb; i++) done_q.push_back('{A_ENVIAR, 1'b0});
            remain = 0;
        end
        busy0 = busy_total;
        done0 = done_total;
        bus.start = 1'b1;
        drive_src(stall, 0);
        while (1) begin
            @(negedge clk);
            pop_now = bus.rd_src;
            d       = bus.done;
            @(posedge clk);
            #1;
            n++;
            if (pop_now) begin
                void'(src_q.pop_front());
                moved++;
            end
            if (d) dones++;
            if (nb == 1 || dones >= nb) bus.start = 1'b0;
            bus.abort = (abort_at > 0) && !aborted && (moved == abort_at);
            if (bus.abort) aborted = 1'b1;
            drive_src(stall, n);
            if (reset_at > 0 && moved == reset_at) begin
                #2 reset = 1'b0;
                #1;
                check("rst_rd_src", {63'd0, bus.rd_src}, 64'd0);
                check("rst_wr_uart", {63'd0, bus.wr_uart}, 64'd0);
                check("rst_busy", {63'd0, bus.busy}, 64'd0);
                check("rst_done", {63'd0, bus.done}, 64'd0);
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                break;
            end
            if (dones >= nb) break;
            if (n > 3000) begin
                fail_now("timeout_waiting_done");
                break;
            end
        end
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.wr_uart_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("words_outstanding", 64'(exp_q.size()), 64'd0);
        check("dones_outstanding", 64'(done_q.size()), 64'd0);
        check("done_count", 64'(done_total - done0), (reset_at > 0) ? 64'd0 : 64'(nb));
        check("src_remaining", 64'(src_q.size()), 64'(remain));
        if (!stall && abort_at == 0 && reset_at == 0)
            check("busy_cycles", 64'(busy_total - busy0), 64'(total));
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        reset            = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.wr_uart_full = 1'b0;
        bus.src_empty    = 1'b1;
        bus.src_data     = 8'h00;
        repeat (3) begin
            @(negedge clk);
            check("reset_rd_src", {63'd0, bus.rd_src}, 64'd0);
            check("reset_busy", {63'd0, bus.busy}, 64'd0);
            check("reset_done", {63'd0, bus.done}, 64'd0);
            check("reset_sent", {48'd0, bus.sent}, 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        bus.src_empty = 1'b0;
        bus.src_data  = 8'hA5;
        // Idle with data available: nothing may move without a start
        repeat (10) begin
            @(negedge clk);
            check("idle_wr_uart", {63'd0, bus.wr_uart}, 64'd0);
            check("idle_busy", {63'd0, bus.busy}, 64'd0);
            check("idle_done", {63'd0, bus.done}, 64'd0);
            check("idle_sent", {48'd0, bus.sent}, 64'd0);
        end
        @(posedge clk);
        #1;
        run(1, 1'b0, 0, 0, 1'b1);
        run(1, 1'b1, 0, 0, 1'b0);
        run(1, 1'b0, 10, 0, 1'b1);
        @(negedge clk);
        check("sent_hold_after_abort", {48'd0, bus.sent}, 64'd10);
        @(posedge clk);
        #1;
        run(2, 1'b0, 0, 0, 1'b0);
        run(1, 1'b0, 0, 5, 1'b1);
        @(negedge clk);
        check("sent_after_reset", {48'd0, bus.sent}, 64'd0);
        @(posedge clk);
        #1;
        run(1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++)
            run(1, 1'b1, 0, 0, 1'b0);
        run(1, 1'b1, int'($urandom_range(1, A_ENVIAR - 1)), 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sincronizador_de_fifo_de_envio.md
Name: sincronizador_de_fifo_de_envio

Overview:
Transmit-side counterpart of the receive-side FIFO synchroniser. On a start request it moves exactly A_ENVIAR words from a source FIFO into the UART transmit FIFO. Each word moves in one cycle, only when the source has data and the UART tx FIFO has room. It sits between the image-processing output FIFO and the uart tx FIFO, and signals completion with a one-cycle done pulse.

Parameters:
A_ENVIAR, 32, number of words transferred per burst (legal range 1..65535)
DATA_W, 8, word width in bits
CNT_W, 16, counter width; must satisfy 2^CNT_W > A_ENVIAR

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  burst request, sampled in IDLE only
abort  input  1  terminate current burst, sampled in XFER only
src_empty  input  1  source FIFO empty flag
src_data  input  DATA_W  source FIFO head word (first-word-fall-through)
rd_src  output  1  pop strobe to source FIFO
wr_uart_full  input  1  UART tx FIFO full flag
wr_uart  output  1  push strobe to UART tx FIFO
w_data  output  DATA_W  word to UART tx FIFO
busy  output  1  high while in XFER
done  output  1  one-cycle pulse at end of burst (normal or aborted)
sent  output  CNT_W  words transferred in current/last burst

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; count=0; sent=0; rd_src=0, wr_uart=0, busy=0, done=0. w_data follows src_data (combinational, don't-care when wr_uart=0).
- FSM states: IDLE, XFER, FIN.
- IDLE: start=1 -> XFER, count cleared to 0. Otherwise stay.
- XFER:
  - move = !src_empty && !wr_uart_full (combinational).
  - rd_src = wr_uart = move, in the same cycle; w_data = src_data.
  - Zero latency: word pushed in the same cycle it is popped.
  - On move, count <= count+1.
  - Exit to FIN when a move occurs with count == A_ENVIAR-1.
- abort=1 in XFER: move forced 0 that cycle, go to FIN, count frozen. abort has priority over a pending move.
- FIN: done=1 for exactly one cycle, busy=0, no strobes; -> IDLE. Back-to-back start: start sampled the next cycle in IDLE; minimum 1 idle cycle between bursts.
- sent mirrors count; holds its final value through IDLE until the next start clears it.
- start while in XFER/FIN: ignored, not queued. abort outside XFER: ignored.
- Stalls: src_empty or wr_uart_full in XFER holds state and count indefinitely, strobes low. No timeout.
- Count compare uses full CNT_W width, with no truncation. A_ENVIAR=1: single move goes straight to FIN.
- Reset mid-burst: immediate return to IDLE. Partially sent words are not reported. Strobes drop asynchronously.
- busy = (state==XFER), decoded from the state register (glitch-free).
- Strobes are never asserted while the respective flag blocks them: rd_src never with src_empty=1, and wr_uart never with wr_uart_full=1.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, start=0 -> all outputs 0, sent=0, state IDLE for 10 cycles.
- Full burst, no stalls: A_ENVIAR=32, source holds 0x00..0x1F, full=0, start pulse -> 32 consecutive wr_uart cycles, w_data=0x00..0x1F in order. done is high in the cycle after the 32nd word; sent=32; busy high for exactly 32 cycles.
- Flow control: toggle wr_uart_full every 3 cycles and src_empty randomly during the burst -> no strobe while either flag is high. Exactly 32 words delivered, order preserved, done once.
- Abort: abort=1 after 10 words -> no 11th push, done pulses next cycle, sent=10, and the source still holds the remaining words.
- Ignored start and back-to-back: start held high throughout a burst -> exactly one done per burst. A new burst begins the first cycle after FIN; sent restarts at 0.
- Reset mid-burst: reset=0 after 5 words -> rd_src/wr_uart drop immediately, busy=0, and no done pulse. After release and start, a fresh 32-word burst completes.
